// File: rtl/key_extractor_pkg.sv
// Shared pipeline definitions: PHV container layout, key/config widths and
// the condition encodings used by key extraction, lookup and action stages.
package key_extractor_pkg;

    localparam int PHV_W     = 1124;
    localparam int KEY_W     = 197;
    localparam int CFG_W     = 123;

    localparam int N48       = 8;
    localparam int W48       = 48;
    localparam int C48_LO    = 740;
    localparam int N32       = 8;
    localparam int W32       = 32;
    localparam int C32_LO    = 484;
    localparam int N16       = 8;
    localparam int W16       = 16;
    localparam int C16_LO    = 356;
    localparam int META_LO   = 256;

    localparam int IDX_LO    = 352;
    localparam int IDX_W     = 4;
    localparam int CFG_DEPTH = 16;
    localparam int SEL_W     = 3;
    localparam int N_COND    = 5;

    typedef enum logic [1:0] {
        OP_OFF = 2'd0,
        OP_EQ  = 2'd1,
        OP_GT  = 2'd2,
        OP_LT  = 2'd3
    } cond_op_e;

    typedef struct packed {
        cond_op_e         op;
        logic [SEL_W-1:0] csel;
        logic [W16-1:0]   imm;
    } cond_t;

    // Field order matches the config entry bit layout, MSB first.
    typedef struct packed {
        logic [SEL_W-1:0]         s48a;
        logic [SEL_W-1:0]         s48b;
        logic [SEL_W-1:0]         s32a;
        logic [SEL_W-1:0]         s32b;
        logic [SEL_W-1:0]         s16a;
        logic [SEL_W-1:0]         s16b;
        cond_t [N_COND-1:0]       cond;
    } cfg_t;

    typedef logic [N16-1:0][W16-1:0] c16_vec_t;

endpackage

// File: rtl/key_extractor_cond.sv
// One condition bit: unsigned compare of a selected 16b container against
// an immediate; an op of OFF always yields 0.
module key_cond_unit
    import key_extractor_pkg::*;
(
    input  c16_vec_t c16,
    input  cond_t    cond,
    output logic     cbit
);

    logic [W16-1:0] val;

    assign val = c16[cond.csel];

    always_comb begin
        cbit = 1'b0;
        case (cond.op)
            OP_EQ:   cbit = (val == cond.imm);
            OP_GT:   cbit = (val >  cond.imm);
            OP_LT:   cbit = (val <  cond.imm);
            default: cbit = 1'b0;
        endcase
    end

endmodule

// File: rtl/key_extractor.sv
// Two-stage key extractor: S1 captures the PHV and its config entry, S2 muxes
// containers, evaluates the conditions and registers key + aligned PHV.
module key_extractor
    import key_extractor_pkg::*;
#(
    parameter int PHV_LEN = PHV_W,
    parameter int KEY_LEN = KEY_W,
    parameter int CFG_LEN = CFG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_valid_in,
    output logic [KEY_LEN-1:0] extract_key,
    output logic               key_valid,
    output logic [PHV_LEN-1:0] phv_out,
    input  logic               cfg_en,
    input  logic [3:0]         cfg_addr,
    input  logic [CFG_LEN-1:0] cfg_data
);

    localparam int STAGES = 2;

    logic [STAGES:1]         vld_pipe;
    logic [PHV_LEN-1:0]      phv_s1;
    cfg_t                    cfg_s1;
    cfg_t                    cfg_table [CFG_DEPTH];
    logic [IDX_W-1:0]        cfg_idx;

    logic [N48-1:0][W48-1:0] c48;
    logic [N32-1:0][W32-1:0] c32;
    c16_vec_t                c16;
    logic [N_COND-1:0]       cbit;
    logic [KEY_LEN-1:0]      key_next;

    assign cfg_idx = phv_in[IDX_LO +: IDX_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[STAGES-1:1], phv_valid_in};
    end

    // Flop-based table; the S1 read below samples the pre-write contents on
    // a colliding edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CFG_DEPTH; i++) cfg_table[i] <= '0;
        end else if (cfg_en) begin
            cfg_table[cfg_addr] <= cfg_t'(cfg_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_s1 <= '0;
            cfg_s1 <= '0;
        end else if (phv_valid_in) begin
            phv_s1 <= phv_in;
            cfg_s1 <= cfg_table[cfg_idx];
        end
    end

    assign c48 = phv_s1[C48_LO +: N48*W48];
    assign c32 = phv_s1[C32_LO +: N32*W32];
    assign c16 = phv_s1[C16_LO +: N16*W16];

    for (genvar i = 0; i < N_COND; i++) begin : g_cond
        key_cond_unit u_cond (
            .c16  (c16),
            .cond (cfg_s1.cond[i]),
            .cbit (cbit[i])
        );
    end

    assign key_next = {c48[cfg_s1.s48a], c48[cfg_s1.s48b],
                       c32[cfg_s1.s32a], c32[cfg_s1.s32b],
                       c16[cfg_s1.s16a], c16[cfg_s1.s16b],
                       cbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            extract_key <= '0;
            phv_out     <= '0;
        end else if (vld_pipe[1]) begin
            extract_key <= key_next;
            phv_out     <= phv_s1;
        end
    end

    assign key_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_key_extractor.sv
// Directed bench for key_extractor with hand-computed keys.
module tb_key_extractor;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1123:0]  phv_in = '0;
    logic           phv_valid_in = 1'b0;
    logic [196:0]   extract_key;
    logic           key_valid;
    logic [1123:0]  phv_out;
    logic           cfg_en = 1'b0;
    logic [3:0]     cfg_addr = '0;
    logic [122:0]   cfg_data = '0;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0]  tag_q [$];
    int           cyc_q [$];
    logic [196:0] key_q [$];

    localparam logic [196:0] K_DEF = {48'h0000AABBCCDD, 48'h0000AABBCCDD,
        32'h12345678, 32'h12345678, 16'hBEEF, 16'hBEEF, 5'b00000};
    localparam logic [196:0] K_EQ1 = {48'h777777777777, 48'h0000AABBCCDD,
        32'h12345678, 32'h12345678, 16'hBEEF, 16'hCAFE, 5'b00001};
    localparam logic [196:0] K_EQ0 = {48'h777777777777, 48'h0000AABBCCDD,
        32'h12345678, 32'h12345678, 16'hBEEF, 16'hCAFE, 5'b00000};
    localparam logic [196:0] K_BND = {48'h0000AABBCCDD, 48'h0000AABBCCDD,
        32'h12345678, 32'h12345678, 16'hBEEF, 16'hBEEF, 5'b01100};
    localparam logic [196:0] K_OLD = {48'h111111111111, 48'h0000AABBCCDD,
        32'h12345678, 32'h12345678, 16'hBEEF, 16'hBEEF, 5'b00000};
    localparam logic [196:0] K_NEW = {48'h777777777777, 48'h0000AABBCCDD,
        32'h12345678, 32'h12345678, 16'hBEEF, 16'hBEEF, 5'b00000};

    key_extractor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .phv_in       (phv_in),
        .phv_valid_in (phv_valid_in),
        .extract_key  (extract_key),
        .key_valid    (key_valid),
        .phv_out      (phv_out),
        .cfg_en       (cfg_en),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_valid) begin
            tag_q.push_back(phv_out[15:0]);
            cyc_q.push_back(cyc);
            key_q.push_back(extract_key);
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [1123:0] mk_phv(input logic [3:0] idx, input logic [15:0] c16_1,
                                             input logic [15:0] c16_2, input logic [15:0] c16_3,
                                             input logic [15:0] tag);
        logic [1123:0] p;
        p = '0;
        p[740  +: 48] = 48'h0000AABBCCDD;
        p[788  +: 48] = 48'h111111111111;
        p[1076 +: 48] = 48'h777777777777;
        p[484  +: 32] = 32'h12345678;
        p[516  +: 32] = 32'h9ABCDEF0;
        p[356  +: 16] = 16'hBEEF;
        p[372  +: 16] = c16_1;
        p[388  +: 16] = c16_2;
        p[404  +: 16] = c16_3;
        p[352  +: 4]  = idx;
        p[200  +: 32] = 32'hDEADBEEF;
        p[15:0]       = tag;
        return p;
    endfunction

    function automatic logic [20:0] mk_cond(input logic [1:0] op, input logic [2:0] csel,
                                            input logic [15:0] imm);
        return {op, csel, imm};
    endfunction

    task automatic cfg_wr(input logic [3:0] addr, input logic [122:0] data);
        cfg_en   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_en   = 1'b0;
        cfg_data = '0;
    endtask

    // Single packet: checks 2-cycle latency, one-cycle pulse and hold.
    task automatic run1(input string name, input logic [1123:0] phv, input logic [196:0] exp);
        phv_in       = phv;
        phv_valid_in = 1'b1;
        tick();
        phv_valid_in = 1'b0;
        chk({name, "_early"}, key_valid, 1'b0);
        tick();
        chk({name, "_kv"}, key_valid, 1'b1);
        chk({name, "_key"}, extract_key, exp);
        chk({name, "_phv"}, phv_out == phv, 1'b1);
        tick();
        chk({name, "_pulse"}, key_valid, 1'b0);
        chk({name, "_hold"}, extract_key, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [122:0] c;

        repeat (2) tick();
        chk("rst_kv", key_valid, 1'b0);
        chk("rst_key", extract_key, '0);
        chk("rst_phv", phv_out == '0, 1'b1);
        rst_n = 1'b1;

        run1("dflt", mk_phv(4'd0, 16'h0800, 16'hCAFE, 16'h0000, 16'h0001), K_DEF);

        c = '0;
        c[122:120] = 3'd7;
        c[107:105] = 3'd2;
        c[20:0]    = mk_cond(2'd1, 3'd1, 16'h0800);
        cfg_wr(4'd3, c);
        run1("eq_hit",  mk_phv(4'd3, 16'h0800, 16'hCAFE, 16'h0000, 16'h0002), K_EQ1);
        run1("eq_miss", mk_phv(4'd3, 16'h86DD, 16'hCAFE, 16'h0000, 16'h0003), K_EQ0);

        cfg_addr = 4'd3;
        cfg_data = '1;
        tick();
        cfg_data = '0;
        run1("en_low", mk_phv(4'd3, 16'h0800, 16'hCAFE, 16'h0000, 16'h0004), K_EQ1);

        c = '0;
        c[104:84] = mk_cond(2'd2, 3'd2, 16'hFFFF);
        c[83:63]  = mk_cond(2'd3, 3'd2, 16'hFFFF);
        c[62:42]  = mk_cond(2'd1, 3'd3, 16'hFFFF);
        c[41:21]  = mk_cond(2'd0, 3'd3, 16'hFFFF);
        c[20:0]   = mk_cond(2'd3, 3'd0, 16'hBEEF);
        cfg_wr(4'd4, c);
        run1("bound", mk_phv(4'd4, 16'h0800, 16'hFFFE, 16'hFFFF, 16'h0005), K_BND);

        tag_q.delete(); cyc_q.delete(); key_q.delete();
        for (int i = 0; i < 10; i++) begin
            phv_in       = mk_phv(4'd0, 16'h0800, 16'hCAFE, 16'h0000, 16'hA000 + 16'(i));
            phv_valid_in = 1'b1;
            tick();
        end
        phv_valid_in = 1'b0;
        repeat (4) tick();
        chk("b2b_cnt", tag_q.size(), 10);
        for (int i = 0; i < 10 && i < tag_q.size(); i++) begin
            chk($sformatf("b2b_tag%0d", i), tag_q[i], 16'hA000 + 16'(i));
            chk($sformatf("b2b_cyc%0d", i), cyc_q[i] - cyc_q[0], i);
        end

        c = '0;
        c[122:120] = 3'd1;
        cfg_wr(4'd5, c);
        tag_q.delete(); cyc_q.delete(); key_q.delete();
        c[122:120]   = 3'd7;
        cfg_en       = 1'b1;
        cfg_addr     = 4'd5;
        cfg_data     = c;
        phv_in       = mk_phv(4'd5, 16'h0800, 16'hCAFE, 16'h0000, 16'h0050);
        phv_valid_in = 1'b1;
        tick();
        cfg_en       = 1'b0;
        cfg_data     = '0;
        phv_in       = mk_phv(4'd5, 16'h0800, 16'hCAFE, 16'h0000, 16'h0051);
        tick();
        phv_valid_in = 1'b0;
        repeat (3) tick();
        chk("rbw_cnt", key_q.size(), 2);
        if (key_q.size() >= 2) begin
            chk("rbw_old", key_q[0], K_OLD);
            chk("rbw_new", key_q[1], K_NEW);
        end

        tag_q.delete(); cyc_q.delete(); key_q.delete();
        phv_in       = mk_phv(4'd3, 16'h0800, 16'hCAFE, 16'h0000, 16'hEE01);
        phv_valid_in = 1'b1;
        tick();
        phv_in       = mk_phv(4'd3, 16'h0800, 16'hCAFE, 16'h0000, 16'hEE02);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_kv", key_valid, 1'b0);
        chk("mid_rst_key", extract_key, '0);
        chk("mid_rst_phv", phv_out == '0, 1'b1);
        phv_valid_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        run1("post_rst3", mk_phv(4'd3, 16'h0800, 16'hCAFE, 16'h0000, 16'hEE03), K_DEF);
        run1("post_rst5", mk_phv(4'd5, 16'h0800, 16'hCAFE, 16'h0000, 16'hEE04), K_DEF);
        chk("flush_cnt", tag_q.size(), 2);
        if (tag_q.size() >= 1) chk("flush_tag", tag_q[0], 16'hEE03);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
